// File: rtl/light_monitor.sv
// Stop-light receiver and checker: tracks colour and dwell time, flags illegal codes,
// out-of-order changes, too-short and too-long dwells, and keeps error/cycle counters.
module light_monitor #(
  parameter int DWELL_MIN = 1,
  parameter int DWELL_MAX = 6,
  parameter int CNT_W     = 4,
  parameter int ERR_W     = 8,
  parameter int CYC_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       light_in,
  input  logic             clear_err,
  output logic [1:0]       color,
  output logic [CNT_W-1:0] dwell,
  output logic             transition,
  output logic             err_illegal,
  output logic             err_order,
  output logic             err_short,
  output logic             err_long,
  output logic             fault,
  output logic [ERR_W-1:0] error_count,
  output logic [CYC_W-1:0] cycle_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [1:0]       GREEN       = 2'b00;
  localparam logic [1:0]       YELLOW      = 2'b01;
  localparam logic [1:0]       RED         = 2'b10;
  localparam logic [1:0]       ILLEGAL     = 2'b11;
  localparam logic [CNT_W-1:0] DWELL_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_LO    = CNT_W'(DWELL_MIN);
  localparam logic [CNT_W-1:0] DWELL_LIMIT = CNT_W'(DWELL_MAX + 1);
  localparam logic [CNT_W-1:0] DWELL_SAT   = {CNT_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_SAT     = {ERR_W{1'b1}};
  localparam logic [CYC_W-1:0] CYC_ONE     = CYC_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] dwell_inc_s;
  logic             same_s;
  logic             e_illegal_s;
  logic             e_order_s;
  logic             e_short_s;
  logic             e_long_s;
  logic             any_err_s;

  function automatic logic [1:0] successor(input logic [1:0] c);
    case (c)
      GREEN:   successor = YELLOW;
      YELLOW:  successor = RED;
      RED:     successor = GREEN;
      default: successor = ILLEGAL;
    endcase
  endfunction

  // Classify the current sample against the tracked colour and dwell.
  always_comb begin
    dwell_inc_s = (dwell == DWELL_SAT) ? dwell : (dwell + DWELL_ONE);
    same_s      = (light_in == color);
    e_illegal_s = 1'b0;
    e_order_s   = 1'b0;
    e_short_s   = 1'b0;
    e_long_s    = 1'b0;
    case (state_r)
      IDLE: begin
        e_illegal_s = (light_in == ILLEGAL);
      end
      TRACK: begin
        if (same_s) begin
          e_long_s = (dwell_inc_s == DWELL_LIMIT);
        end else begin
          e_illegal_s = (light_in == ILLEGAL);
          e_order_s   = (light_in != ILLEGAL) && (light_in != successor(color));
          e_short_s   = (dwell < DWELL_LO);
        end
      end
      default: begin
        e_illegal_s = 1'b0;
      end
    endcase
    any_err_s = e_illegal_s | e_order_s | e_short_s | e_long_s;
  end

  // Monitor FSM with all outputs registered; clear_err overrides enable and errors.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      color       <= GREEN;
      dwell       <= '0;
      transition  <= 1'b0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      fault       <= 1'b0;
      error_count <= '0;
      cycle_count <= '0;
    end else if (clear_err) begin
      state_r     <= IDLE;
      dwell       <= '0;
      transition  <= 1'b0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      fault       <= 1'b0;
      error_count <= '0;
    end else if (!enable) begin
      transition  <= 1'b0;
      err_illegal <= 1'b0;
      err_order   <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      transition  <= 1'b0;
      err_illegal <= e_illegal_s;
      err_order   <= e_order_s;
      err_short   <= e_short_s;
      err_long    <= e_long_s;
      if (any_err_s) begin
        fault <= 1'b1;
        if (error_count != ERR_SAT) begin
          error_count <= error_count + ERR_ONE;
        end else begin
          error_count <= error_count;
        end
      end else begin
        fault <= fault;
      end
      case (state_r)
        IDLE: begin
          if (light_in != ILLEGAL) begin
            color   <= light_in;
            dwell   <= DWELL_ONE;
            state_r <= TRACK;
          end else begin
            state_r <= IDLE;
          end
        end
        TRACK: begin
          if (same_s) begin
            dwell   <= dwell_inc_s;
            state_r <= e_long_s ? FAULT : TRACK;
          end else if (any_err_s) begin
            state_r <= FAULT;
          end else begin
            transition <= 1'b1;
            color      <= light_in;
            dwell      <= DWELL_ONE;
            if (light_in == GREEN) begin
              cycle_count <= cycle_count + CYC_ONE;
            end else begin
              cycle_count <= cycle_count;
            end
          end
        end
        FAULT: begin
          state_r <= FAULT;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_monitor.sv
// Bench for light_monitor: two instances (DWELL_MIN=1 and 3) share inputs and are
// compared every cycle against an arithmetic model of the colour/dwell rules.
module tb_light_monitor;

  localparam int DMAX = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       clear_err = 1'b0;
  logic [1:0] light_in = 2'b00;

  logic [1:0] o0_color, o1_color;
  logic [3:0] o0_dwell, o1_dwell;
  logic       o0_tr, o0_ei, o0_eo, o0_es, o0_el, o0_fault;
  logic       o1_tr, o1_ei, o1_eo, o1_es, o1_el, o1_fault;
  logic [7:0] o0_ec, o0_cc, o1_ec, o1_cc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int st;  // 0 idle, 1 track, 2 fault
    int color, dwell, tr, ei, eo, es, el, fault, ecnt, ccnt;
  } mdl_t;

  mdl_t m0, m1;

  always #5 clk = ~clk;

  light_monitor u0 (
    .clk(clk), .reset(reset), .enable(enable), .light_in(light_in), .clear_err(clear_err),
    .color(o0_color), .dwell(o0_dwell), .transition(o0_tr), .err_illegal(o0_ei),
    .err_order(o0_eo), .err_short(o0_es), .err_long(o0_el), .fault(o0_fault),
    .error_count(o0_ec), .cycle_count(o0_cc)
  );

  light_monitor #(.DWELL_MIN(3)) u1 (
    .clk(clk), .reset(reset), .enable(enable), .light_in(light_in), .clear_err(clear_err),
    .color(o1_color), .dwell(o1_dwell), .transition(o1_tr), .err_illegal(o1_ei),
    .err_order(o1_eo), .err_short(o1_es), .err_long(o1_el), .fault(o1_fault),
    .error_count(o1_ec), .cycle_count(o1_cc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t step(input mdl_t m, input int dmin, input bit rst, input bit en,
                                input bit clr, input int li);
    mdl_t n = m;
    n.tr = 0; n.ei = 0; n.eo = 0; n.es = 0; n.el = 0;
    if (!rst) begin
      n.st = 0; n.color = 0; n.dwell = 0; n.fault = 0; n.ecnt = 0; n.ccnt = 0;
      return n;
    end
    if (clr) begin
      n.st = 0; n.fault = 0; n.ecnt = 0; n.dwell = 0;
      return n;
    end
    if (!en) return n;
    if (m.st == 0) begin
      if (li == 3) n.ei = 1;
      else begin n.color = li; n.dwell = 1; n.st = 1; end
    end else if (m.st == 1) begin
      if (li == m.color) begin
        n.dwell = (m.dwell + 1 > 15) ? 15 : m.dwell + 1;
        if (n.dwell == DMAX + 1) begin n.el = 1; n.st = 2; end
      end else begin
        n.ei = (li == 3);
        n.eo = (li != 3) && (li != (m.color + 1) % 3);
        n.es = (m.dwell < dmin);
        if (n.ei || n.eo || n.es) n.st = 2;
        else begin
          n.tr = 1; n.color = li; n.dwell = 1;
          if (li == 0) n.ccnt = (m.ccnt + 1) % 256;
        end
      end
    end
    if (n.ei || n.eo || n.es || n.el) begin
      n.fault = 1;
      n.ecnt = (m.ecnt < 255) ? m.ecnt + 1 : 255;
    end
    return n;
  endfunction

  task automatic cmp(input string p, input mdl_t e, input logic [1:0] col, input logic [3:0] dw,
                     input logic tr, input logic ei, input logic eo, input logic es,
                     input logic el, input logic ft, input logic [7:0] ec, input logic [7:0] cc);
    check({p, ".color"}, 32'(col), 32'(e.color));
    check({p, ".dwell"}, 32'(dw), 32'(e.dwell));
    check({p, ".transition"}, 32'(tr), 32'(e.tr));
    check({p, ".err_illegal"}, 32'(ei), 32'(e.ei));
    check({p, ".err_order"}, 32'(eo), 32'(e.eo));
    check({p, ".err_short"}, 32'(es), 32'(e.es));
    check({p, ".err_long"}, 32'(el), 32'(e.el));
    check({p, ".fault"}, 32'(ft), 32'(e.fault));
    check({p, ".error_count"}, 32'(ec), 32'(e.ecnt));
    check({p, ".cycle_count"}, 32'(cc), 32'(e.ccnt));
  endtask

  task automatic tick(input bit rst, input bit en, input bit clr, input logic [1:0] li);
    reset = rst; enable = en; clear_err = clr; light_in = li;
    @(posedge clk);
    m0 = step(m0, 1, rst, en, clr, int'(li));
    m1 = step(m1, 3, rst, en, clr, int'(li));
    #1;
    cmp("u0", m0, o0_color, o0_dwell, o0_tr, o0_ei, o0_eo, o0_es, o0_el, o0_fault, o0_ec, o0_cc);
    cmp("u1", m1, o1_color, o1_dwell, o1_tr, o1_ei, o1_eo, o1_es, o1_el, o1_fault, o1_ec, o1_cc);
  endtask

  task automatic feed(input logic [1:0] li, input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0, li);
  endtask

  initial begin
    int tgt, hold, r;
    logic [1:0] li;
    bit rst, clr, en;
    m0 = '{default: 0};
    m1 = '{default: 0};

    // Reset, then one full legal cycle.
    tick(1'b0, 1'b1, 1'b0, 2'b00);
    tick(1'b0, 1'b1, 1'b0, 2'b00);
    check("reset.dwell", 32'(o0_dwell), 32'd0);
    feed(2'b00, 3); feed(2'b01, 3); feed(2'b10, 3); feed(2'b00, 1);
    check("plan1.cycle_count", 32'(o0_cc), 32'd1);
    check("plan1.fault", 32'(o0_fault), 32'd0);

    // Green to Red after three cycles is an order error.
    feed(2'b00, 2); feed(2'b10, 1);
    check("plan2.err_order", 32'(o0_eo), 32'd1);
    check("plan2.error_count", 32'(o0_ec), 32'd1);
    check("plan2.color", 32'(o0_color), 32'd0);
    feed(2'b10, 1);
    check("plan2.pulse_drop", 32'(o0_eo), 32'd0);

    // Short dwell with DWELL_MIN=3, alone and combined with an order error.
    tick(1'b1, 1'b1, 1'b1, 2'b00);
    feed(2'b00, 2); feed(2'b01, 1);
    check("plan3.short", 32'(o1_es), 32'd1);
    check("plan3.short_only", 32'(o1_eo), 32'd0);
    check("plan3.count", 32'(o1_ec), 32'd1);
    tick(1'b1, 1'b1, 1'b1, 2'b00);
    feed(2'b00, 1); feed(2'b10, 1);
    check("plan3.both_order", 32'(o1_eo), 32'd1);
    check("plan3.both_short", 32'(o1_es), 32'd1);
    check("plan3.both_count", 32'(o1_ec), 32'd1);

    // Overlong dwell then frozen in FAULT.
    tick(1'b1, 1'b1, 1'b1, 2'b01);
    feed(2'b01, 7);
    check("plan4.err_long", 32'(o0_el), 32'd1);
    check("plan4.dwell", 32'(o0_dwell), 32'd7);
    feed(2'b01, 2);
    check("plan4.no_pulse", 32'(o0_el), 32'd0);
    check("plan4.frozen", 32'(o0_dwell), 32'd7);

    // Illegal code in IDLE, clear, then accept Yellow.
    tick(1'b1, 1'b1, 1'b1, 2'b11);
    feed(2'b11, 1);
    check("plan5.illegal", 32'(o0_ei), 32'd1);
    check("plan5.fault", 32'(o0_fault), 32'd1);
    tick(1'b1, 1'b0, 1'b1, 2'b11);
    check("plan5.clr_fault", 32'(o0_fault), 32'd0);
    check("plan5.clr_count", 32'(o0_ec), 32'd0);
    feed(2'b01, 1);
    check("plan5.color", 32'(o0_color), 32'd1);
    check("plan5.dwell", 32'(o0_dwell), 32'd1);

    // Enable low while the code moves, then reset mid-dwell.
    feed(2'b01, 2);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 2'(i));
    check("plan6.dwell_hold", 32'(o0_dwell), 32'd3);
    tick(1'b0, 1'b1, 1'b0, 2'b01);
    check("plan6.reset_color", 32'(o0_color), 32'd0);

    // error_count saturation: illegal code every cycle in IDLE.
    tick(1'b1, 1'b1, 1'b1, 2'b11);
    feed(2'b11, 260);
    check("sat.error_count", 32'(o0_ec), 32'd255);

    // cycle_count wrap after 256 completed cycles.
    tick(1'b0, 1'b1, 1'b0, 2'b00);
    feed(2'b00, 1);
    for (int i = 0; i < 256; i++) begin feed(2'b01, 1); feed(2'b10, 1); feed(2'b00, 1); end
    check("wrap.cycle_count", 32'(o0_cc), 32'd0);

    // Randomized traffic mostly following the legal order.
    tgt = 0; hold = 3;
    for (int i = 0; i < 2500; i++) begin
      r = int'($urandom_range(0, 99));
      rst = (r >= 2);
      clr = (r >= 2 && r < 6);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) li = 2'($urandom_range(0, 3));
      else li = 2'(tgt);
      tick(rst, en, clr, li);
      if (en) hold--;
      if (hold <= 0) begin
        tgt = ($urandom_range(0, 9) != 0) ? (tgt + 1) % 3 : int'($urandom_range(0, 2));
        hold = int'($urandom_range(1, 8));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
